mem_arbiter: RTL

//   Two-requester arbiter that shares one cache/memory port (addr/avalid/aready, wdata/wstrb,

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory request/response port between instruction
// fetch (port 0) and load/store (port 1); one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [DATA_W/8-1:0]   req0_wstrb,
  input  logic                  req0_avalid,
  output logic                  req0_aready,
  output logic [DATA_W-1:0]     req0_rdata,
  output logic                  req0_bvalid,
  input  logic                  req0_bready,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [DATA_W/8-1:0]   req1_wstrb,
  input  logic                  req1_avalid,
  output logic                  req1_aready,
  output logic [DATA_W-1:0]     req1_rdata,
  output logic                  req1_bvalid,
  input  logic                  req1_bready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_avalid,
  input  logic                  mem_aready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_bvalid,
  output logic                  mem_bready,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic                gnt;
  logic                last_gnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic                any_req;
  logic                pick;
  logic                live;
  logic                in_idle;
  logic                in_addr;
  logic                in_resp;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    any_req = req0_avalid | req1_avalid;
    pick    = 1'b0;
    if (req0_avalid && req1_avalid) begin
      pick = RR_EN ? ~last_gnt : 1'b0;
    end else if (req1_avalid) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= pick;
            addr_q  <= pick ? req1_addr  : req0_addr;
            wdata_q <= pick ? req1_wdata : req0_wdata;
            wstrb_q <= pick ? req1_wstrb : req0_wstrb;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (mem_aready) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_bvalid && mem_bready) begin
            last_gnt <= gnt;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is forced quiet while reset is asserted so an abandoned
  // response never leaks through to a requester.
  always_comb begin
    live    = ~rst;
    in_idle = live && (state == IDLE);
    in_addr = live && (state == ADDR);
    in_resp = live && (state == RESP);

    req0_aready = in_idle & any_req & ~pick;
    req1_aready = in_idle & any_req & pick;

    mem_avalid = in_addr;
    mem_addr   = live ? addr_q  : '0;
    mem_wdata  = live ? wdata_q : '0;
    mem_wstrb  = live ? wstrb_q : '0;

    mem_bready  = in_resp & (gnt ? req1_bready : req0_bready);
    req0_bvalid = in_resp & ~gnt & mem_bvalid;
    req1_bvalid = in_resp &  gnt & mem_bvalid;
    req0_rdata  = req0_bvalid ? mem_rdata : '0;
    req1_rdata  = req1_bvalid ? mem_rdata : '0;

    busy = live && (state != IDLE);
  end

endmodule
